// File: rtl/bounce_shift_gen.sv
// One-hot token register that walks back and forth (or rotates) across N bits
// at a programmable step rate, with end-of-travel pulses and an LSB-hit counter.
module bounce_shift_gen #(
  parameter  int N             = 8,
  parameter  int COUNTER_WIDTH = 8,
  parameter  int DIV_WIDTH     = 8,
  localparam int PW            = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rstna,
  input  logic                     ena,
  input  logic [1:0]               mode,
  input  logic [DIV_WIDTH-1:0]     div,
  input  logic                     load,
  input  logic [PW-1:0]            load_pos,
  input  logic                     clr_cnt,
  output logic [N-1:0]             Q,
  output logic                     dir,
  output logic                     tc_lsb,
  output logic                     tc_msb,
  output logic [COUNTER_WIDTH-1:0] period_count,
  output logic                     cnt_ovf
);

  typedef enum logic [1:0] {
    M_BOUNCE = 2'b00,
    M_ROTR   = 2'b01,
    M_ROTL   = 2'b10,
    M_FREEZE = 2'b11
  } mode_e;

  localparam logic [N-1:0]             Q_RST   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]             Q_ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]     PRE_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  mode_e                md;
  logic [DIV_WIDTH-1:0] pre, pre_nxt;
  logic                 step;
  logic [PW-1:0]        pos;
  logic [N-1:0]         q_load, q_nxt;
  logic                 dir_nxt;
  logic                 moved;
  logic                 lsb_nxt, msb_nxt;

  assign md = mode_e'(mode);

  // Clamp only exists when the load_pos range can exceed N-1.
  if ((2 ** PW) > N) begin : g_clamp
    assign pos = (load_pos > PW'(N - 1)) ? PW'(N - 1) : load_pos;
  end else begin : g_noclamp
    assign pos = load_pos;
  end

  assign q_load = Q_ONE << pos;

  // >= rather than == so a div lowered below the running count steps at once
  // instead of wrapping through the whole prescaler range.
  assign step = ena && (pre >= div);

  always_comb begin
    pre_nxt = pre;
    if (load)
      pre_nxt = '0;
    else if (ena)
      pre_nxt = step ? '0 : pre + PRE_ONE;
  end

  always_comb begin
    q_nxt   = Q;
    dir_nxt = dir;
    moved   = 1'b0;
    if (load) begin
      q_nxt = q_load;
    end else if (step) begin
      case (md)
        M_BOUNCE: begin
          moved = 1'b1;
          if (dir) begin
            if (Q[0]) begin
              q_nxt   = Q << 1;
              dir_nxt = 1'b0;
            end else begin
              q_nxt = Q >> 1;
            end
          end else begin
            if (Q[N-1]) begin
              q_nxt   = Q >> 1;
              dir_nxt = 1'b1;
            end else begin
              q_nxt = Q << 1;
            end
          end
        end
        M_ROTR: begin
          moved   = 1'b1;
          q_nxt   = {Q[0], Q[N-1:1]};
          dir_nxt = 1'b1;
        end
        M_ROTL: begin
          moved   = 1'b1;
          q_nxt   = {Q[N-2:0], Q[N-1]};
          dir_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A reflection never lands on an end bit, so it cannot raise a pulse here.
  assign lsb_nxt = moved && q_nxt[0];
  assign msb_nxt = moved && q_nxt[N-1];

  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      pre    <= '0;
      Q      <= Q_RST;
      dir    <= 1'b1;
      tc_lsb <= 1'b0;
      tc_msb <= 1'b0;
    end else begin
      pre    <= pre_nxt;
      Q      <= q_nxt;
      dir    <= dir_nxt;
      tc_lsb <= lsb_nxt;
      tc_msb <= msb_nxt;
    end
  end

  // Counter advances in the same cycle tc_lsb is registered.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      period_count <= '0;
      cnt_ovf      <= 1'b0;
    end else if (clr_cnt) begin
      period_count <= '0;
      cnt_ovf      <= 1'b0;
    end else if (lsb_nxt) begin
      if (&period_count)
        cnt_ovf <= 1'b1;
      else
        period_count <= period_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_bounce_shift_gen.sv
// Directed bench: a vector table for the free-running bounce, then hand
// sequences for prescaler, modes, saturation, load and async reset.
module tb_bounce_shift_gen;

  logic       clk = 1'b0;
  logic       rstna;
  logic       ena;
  logic [1:0] mode;
  logic [7:0] div;
  logic       load;
  logic [2:0] load_pos;
  logic       clr_cnt;

  logic [7:0] q;   logic dir;  logic lsb;  logic msb;  logic [7:0] cnt;  logic ovf;
  logic [7:0] q2;  logic dir2; logic lsb2; logic msb2; logic [1:0] cnt2; logic ovf2;
  logic [5:0] q6;  logic dir6; logic lsb6; logic msb6; logic [7:0] cnt6; logic ovf6;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bounce_shift_gen #(.N(8), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) u_dut (
    .clk(clk), .rstna(rstna), .ena(ena), .mode(mode), .div(div), .load(load),
    .load_pos(load_pos), .clr_cnt(clr_cnt), .Q(q), .dir(dir), .tc_lsb(lsb),
    .tc_msb(msb), .period_count(cnt), .cnt_ovf(ovf));

  bounce_shift_gen #(.N(8), .COUNTER_WIDTH(2), .DIV_WIDTH(8)) u_c2 (
    .clk(clk), .rstna(rstna), .ena(ena), .mode(mode), .div(div), .load(load),
    .load_pos(load_pos), .clr_cnt(clr_cnt), .Q(q2), .dir(dir2), .tc_lsb(lsb2),
    .tc_msb(msb2), .period_count(cnt2), .cnt_ovf(ovf2));

  bounce_shift_gen #(.N(6), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) u_n6 (
    .clk(clk), .rstna(rstna), .ena(ena), .mode(mode), .div(div), .load(load),
    .load_pos(load_pos), .clr_cnt(clr_cnt), .Q(q6), .dir(dir6), .tc_lsb(lsb6),
    .tc_msb(msb6), .period_count(cnt6), .cnt_ovf(ovf6));

  typedef struct {
    logic       e;
    logic [1:0] m;
    logic [7:0] d;
    logic       cl;
    logic [7:0] q;
    logic       dr;
    logic       tl;
    logic       tm;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic [7:0] eq, input logic edr, input logic etl,
                              input logic etm, input logic [7:0] ec);
    vec_t v;
    v.e = 1'b1; v.m = 2'b00; v.d = 8'd0; v.cl = 1'b0;
    v.q = eq; v.dr = edr; v.tl = etl; v.tm = etm; v.c = ec;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Main and COUNTER_WIDTH=2 instances share inputs, so Q/dir/pulses agree.
  task automatic chk(input string nm, input logic [7:0] eq, input logic ed,
                     input logic el, input logic em, input logic [7:0] ec);
    cmp({nm, " Q"},    64'(q),    64'(eq));
    cmp({nm, " dir"},  64'(dir),  64'(ed));
    cmp({nm, " lsb"},  64'(lsb),  64'(el));
    cmp({nm, " msb"},  64'(msb),  64'(em));
    cmp({nm, " cnt"},  64'(cnt),  64'(ec));
    cmp({nm, " ovf"},  64'(ovf),  64'(0));
    cmp({nm, " Q2"},   64'(q2),   64'(eq));
    cmp({nm, " dir2"}, 64'(dir2), 64'(ed));
    cmp({nm, " lsb2"}, 64'(lsb2), 64'(el));
    cmp({nm, " msb2"}, 64'(msb2), 64'(em));
  endtask

  task automatic chk2(input string nm, input logic [1:0] ec, input logic eo);
    cmp({nm, " cnt2"}, 64'(cnt2), 64'(ec));
    cmp({nm, " ovf2"}, 64'(ovf2), 64'(eo));
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, 8'h80, 1'b1, 1'b0, 1'b0, 8'd0);
    chk2(nm, 2'd0, 1'b0);
    cmp({nm, " Q6"},   64'(q6),   64'(6'h20));
    cmp({nm, " dir6"}, 64'(dir6), 64'(1));
    cmp({nm, " lsb6"}, 64'(lsb6), 64'(0));
    cmp({nm, " msb6"}, 64'(msb6), 64'(0));
    cmp({nm, " cnt6"}, 64'(cnt6), 64'(0));
    cmp({nm, " ovf6"}, 64'(ovf6), 64'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(8'h40, 1, 0, 0, 0);
    tbl[1]  = mk(8'h20, 1, 0, 0, 0);
    tbl[2]  = mk(8'h10, 1, 0, 0, 0);
    tbl[3]  = mk(8'h08, 1, 0, 0, 0);
    tbl[4]  = mk(8'h04, 1, 0, 0, 0);
    tbl[5]  = mk(8'h02, 1, 0, 0, 0);
    tbl[6]  = mk(8'h01, 1, 1, 0, 1);
    tbl[7]  = mk(8'h02, 0, 0, 0, 1);
    tbl[8]  = mk(8'h04, 0, 0, 0, 1);
    tbl[9]  = mk(8'h08, 0, 0, 0, 1);
    tbl[10] = mk(8'h10, 0, 0, 0, 1);
    tbl[11] = mk(8'h20, 0, 0, 0, 1);
    tbl[12] = mk(8'h40, 0, 0, 0, 1);
    tbl[13] = mk(8'h80, 0, 0, 1, 1);
    tbl[14] = mk(8'h40, 1, 0, 0, 1);
    tbl[15] = mk(8'h20, 1, 0, 0, 1);

    rstna = 1'b0; ena = 1'b0; mode = 2'b00; div = 8'd0;
    load = 1'b0; load_pos = 3'd0; clr_cnt = 1'b0;
    tick();
    chk_rst("reset");
    rstna = 1'b1;

    // Free-running bounce, div=0
    for (int i = 0; i < 16; i++) begin
      ena = tbl[i].e; mode = tbl[i].m; div = tbl[i].d; clr_cnt = tbl[i].cl;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].q, tbl[i].dr, tbl[i].tl, tbl[i].tm, tbl[i].c);
    end
    chk2("vec_end", 2'd1, 1'b0);

    // Load while a step is due: no move, no pulse, prescaler restarts
    load = 1'b1; load_pos = 3'd3;
    tick();
    chk("load3", 8'h08, 1, 0, 0, 1);
    cmp("load3 Q6", 64'(q6), 64'(6'h08));
    load = 1'b0;

    // div=3 with freeze at the start: prescaler keeps running while frozen
    div = 8'd3; mode = 2'b11;
    tick(); chk("frz1", 8'h08, 1, 0, 0, 1);
    tick(); chk("frz2", 8'h08, 1, 0, 0, 1);
    mode = 2'b00;
    tick(); chk("div3a", 8'h08, 1, 0, 0, 1);
    tick(); chk("div3b", 8'h04, 1, 0, 0, 1);
    tick(); chk("div3c", 8'h04, 1, 0, 0, 1);
    tick(); chk("div3d", 8'h04, 1, 0, 0, 1);

    // ena low mid-count: everything holds, prescaler resumes at its value
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk($sformatf("hold%0d", i), 8'h04, 1, 0, 0, 1);
    end
    ena = 1'b1;
    tick(); chk("resume1", 8'h04, 1, 0, 0, 1);
    tick(); chk("resume2", 8'h02, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("div3w%0d", i), 8'h02, 1, 0, 0, 1);
    end
    tick(); chk("div3lsb", 8'h01, 1, 1, 0, 2);
    chk2("ev2", 2'd2, 1'b0);

    // Rotations
    div = 8'd0; mode = 2'b01;
    tick(); chk("rotr_wrap", 8'h80, 1, 0, 1, 2);
    mode = 2'b10;
    tick(); chk("rotl_wrap", 8'h01, 0, 1, 0, 3);
    chk2("ev3", 2'd3, 1'b0);
    tick(); chk("rotl", 8'h02, 0, 0, 0, 3);
    mode = 2'b11;
    tick(); chk("freeze1", 8'h02, 0, 0, 0, 3);
    tick(); chk("freeze2", 8'h02, 0, 0, 0, 3);
    mode = 2'b01;
    tick(); chk("rotr_lsb", 8'h01, 1, 1, 0, 4);
    chk2("ev4_sat", 2'd3, 1'b1);

    // Entering bounce at bit 0 pointing outward reflects without a pulse
    mode = 2'b00;
    tick(); chk("reflect_lsb", 8'h02, 0, 0, 0, 4);
    chk2("after_sat", 2'd3, 1'b1);

    // Clear coincident with a tc_lsb wins
    mode = 2'b01; clr_cnt = 1'b1;
    tick(); chk("clr_win", 8'h01, 1, 1, 0, 0);
    chk2("clr_win", 2'd0, 1'b0);
    clr_cnt = 1'b0;

    // Load to N-1 keeps dir, no msb pulse; N=6 clamps to bit 5
    mode = 2'b10;
    tick(); chk("rotl2", 8'h02, 0, 0, 0, 0);
    load = 1'b1; load_pos = 3'd7;
    tick(); chk("load7", 8'h80, 0, 0, 0, 0);
    cmp("load7 Q6", 64'(q6), 64'(6'h20));
    load = 1'b0; mode = 2'b00;
    tick(); chk("reflect_msb", 8'h40, 1, 0, 0, 0);
    mode = 2'b10;
    tick(); chk("rotl_msb", 8'h80, 0, 0, 1, 0);
    tick(); chk("rotl_lsb", 8'h01, 0, 1, 0, 1);
    chk2("ev_after_clr", 2'd1, 1'b0);

    // Asynchronous reset mid-operation, between clock edges
    mode = 2'b00; div = 8'd3;
    #3 rstna = 1'b0;
    #1 chk_rst("async_rst");
    tick();
    chk_rst("rst_held");
    rstna = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("post_rst%0d", i), 8'h80, 1, 0, 0, 0);
    end
    tick(); chk("post_rst_step", 8'h40, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
